async_fifo: RTL and testbench

- Parameterised FIFO buffer between a producer and a consumer, with full/empty flow-control flags.
- Kept under the asyncfifo interface family, but both the write and read sides run in one clock domain.
- No clock-domain crossing logic is needed.
- Used as a generic elastic byte buffer in datapaths.

---
 rtl/async_fifo_pkg.sv | 13 +
 rtl/async_fifo_mem.sv | 40 ++++
 rtl/async_fifo.sv | 89 ++++++++
 tb/tb_async_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the single-clock async_fifo buffer.
package async_fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned ADD_SIZE   = 4;
    localparam int unsigned DATA_WIDTH = 8;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int unsigned depth      = FIFO_DEPTH,
    parameter int unsigned addr_width = ADD_SIZE - 1,
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Output word holds unless a read is accepted; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with full/empty flags.
// Optional status outputs (data_count, almost_full, almost_empty) are built
// when ASYNC_FIFO_STATUS_EN is defined.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned fifo_depth = FIFO_DEPTH,
    parameter int unsigned add_size   = ptr_width(fifo_depth),
    parameter int unsigned data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [data_width-1:0] write_data,
    output logic [data_width-1:0] read_data,
    output logic                  empty,
    output logic                  full
`ifdef ASYNC_FIFO_STATUS_EN
    ,
    output logic [add_size-1:0]   data_count,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    logic [add_size-1:0] wr_ptr_q, wr_ptr_d;
    logic [add_size-1:0] rd_ptr_q, rd_ptr_d;
    logic                wr_fire, rd_fire;

    // Flags come straight from the registered pointers.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[add_size-1] != rd_ptr_q[add_size-1]) &&
                   (wr_ptr_q[add_size-2:0] == rd_ptr_q[add_size-2:0]);

    // Requests are gated by the pre-edge flags.
    assign wr_fire = wr_en && !full && !rst;
    assign rd_fire = rd_en && !empty && !rst;

    // Next-state pointers, wrapping modulo 2^add_size.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    async_fifo_mem #(
        .depth      (fifo_depth),
        .addr_width (add_size - 1),
        .data_width (data_width)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr (wr_ptr_q[add_size-2:0]),
        .wdata (write_data),
        .re    (rd_fire),
        .raddr (rd_ptr_q[add_size-2:0]),
        .rdata (read_data)
    );

`ifdef ASYNC_FIFO_STATUS_EN
    localparam logic [add_size-1:0] AlmostFullLvl = add_size'(fifo_depth - 1);

    // Occupancy and threshold flags, combinational from the pointers.
    always_comb begin
        data_count   = wr_ptr_q - rd_ptr_q;
        almost_full  = (data_count >= AlmostFullLvl);
        almost_empty = (data_count <= add_size'(1));
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo.
module tb_async_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
`ifdef ASYNC_FIFO_STATUS_EN
    logic [3:0] data_count;
    logic       almost_full;
    logic       almost_empty;
`endif

    int passed = 0;
    int total  = 0;

    async_fifo #(
        .fifo_depth (8),
        .add_size   (4),
        .data_width (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full)
`ifdef ASYNC_FIFO_STATUS_EN
        ,
        .data_count   (data_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; write_data = 8'hAA;
        tick();
        tick();
        total++;
        if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
        total++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        total++;
        if (read_data !== 8'h00) $display("FAIL reset_rdata: got %h want 00", read_data);
        else passed++;
`ifdef ASYNC_FIFO_STATUS_EN
        total++;
        if ({data_count, almost_full, almost_empty} !== {4'd0, 1'b0, 1'b1})
            $display("FAIL reset_status: got %h %b %b want 0 0 1",
                     data_count, almost_full, almost_empty);
        else passed++;
`endif
        rst = 1'b0;
        idle();
        tick();
        total++;
        if (empty !== 1'b1 || full !== 1'b0)
            $display("FAIL reset_release: got empty=%b full=%b want 1 0", empty, full);
        else passed++;
    endtask

    task automatic test_fill_drain();
        logic [7:0] v [8];
        v = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; write_data = v[i];
            tick();
            total++;
            if (empty !== 1'b0 || full !== (i == 7))
                $display("FAIL fill_%0d: got empty=%b full=%b want 0 %b", i, empty, full, i == 7);
            else passed++;
        end
`ifdef ASYNC_FIFO_STATUS_EN
        total++;
        if ({data_count, almost_full, almost_empty} !== {4'd8, 1'b1, 1'b0})
            $display("FAIL full_status: got %h %b %b want 8 1 0",
                     data_count, almost_full, almost_empty);
        else passed++;
`endif
        write_data = 8'hFF;
        tick();
        total++;
        if (full !== 1'b1) $display("FAIL overflow_full: got %b want 1", full); else passed++;
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            total++;
            if (read_data !== v[i] || empty !== (i == 7) || full !== 1'b0)
                $display("FAIL drain_%0d: got %h empty=%b full=%b want %h %b 0",
                         i, read_data, empty, full, v[i], i == 7);
            else passed++;
        end
        tick();
        total++;
        if (read_data !== 8'h12 || empty !== 1'b1)
            $display("FAIL underflow_hold: got %h empty=%b want 12 1", read_data, empty);
        else passed++;
        idle();
    endtask

    task automatic test_wrap();
        // Park the pointers at address 6 so the next writes cross 7 -> 0.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; write_data = 8'h70 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        total++;
        if (read_data !== 8'h75 || empty !== 1'b1)
            $display("FAIL wrap_pre: got %h empty=%b want 75 1", read_data, empty);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; write_data = 8'h01 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            total++;
            if (read_data !== 8'h01 + 8'(i))
                $display("FAIL wrap_rd_%0d: got %h want %h", i, read_data, 8'h01 + 8'(i));
            else passed++;
        end
        idle();
        total++;
        if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passed++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [6];
        exp = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        wr_en = 1'b1; write_data = 8'hA1; tick();
        write_data = 8'hA2; tick();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; write_data = 8'hB1 + 8'(i);
            tick();
            total++;
            if (read_data !== exp[i] || empty !== 1'b0 || full !== 1'b0)
                $display("FAIL simul_%0d: got %h empty=%b full=%b want %h 0 0",
                         i, read_data, empty, full, exp[i]);
            else passed++;
        end
        wr_en = 1'b0;
        for (int i = 4; i < 6; i++) begin
            rd_en = 1'b1;
            tick();
            total++;
            if (read_data !== exp[i] || empty !== (i == 5))
                $display("FAIL simul_drain_%0d: got %h empty=%b want %h %b",
                         i, read_data, empty, exp[i], i == 5);
            else passed++;
        end
        idle();
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; write_data = 8'hC0 + 8'(i);
            tick();
        end
        total++;
        if (full !== 1'b1) $display("FAIL bnd_full_pre: got %b want 1", full); else passed++;
        wr_en = 1'b1; rd_en = 1'b1; write_data = 8'hEE;
        tick();
        total++;
        if (read_data !== 8'hC0 || full !== 1'b0 || empty !== 1'b0)
            $display("FAIL bnd_full_both: got %h full=%b empty=%b want c0 0 0",
                     read_data, full, empty);
        else passed++;
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            total++;
            if (read_data !== 8'hC0 + 8'(i))
                $display("FAIL bnd_drain_%0d: got %h want %h", i, read_data, 8'hC0 + 8'(i));
            else passed++;
        end
        total++;
        if (empty !== 1'b1) $display("FAIL bnd_dropped: got empty=%b want 1", empty);
        else passed++;
        wr_en = 1'b1; rd_en = 1'b1; write_data = 8'h5A;
        tick();
        total++;
        if (read_data !== 8'hC7 || empty !== 1'b0)
            $display("FAIL bnd_empty_both: got %h empty=%b want c7 0", read_data, empty);
        else passed++;
        wr_en = 1'b0;
        tick();
        total++;
        if (read_data !== 8'h5A || empty !== 1'b1)
            $display("FAIL bnd_empty_rd: got %h empty=%b want 5a 1", read_data, empty);
        else passed++;
        idle();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; write_data = 8'h30 + 8'(i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || read_data !== 8'h00)
            $display("FAIL midrst: got empty=%b full=%b rdata=%h want 1 0 00",
                     empty, full, read_data);
        else passed++;
        rd_en = 1'b1;
        tick();
        idle();
        total++;
        if (read_data !== 8'h00 || empty !== 1'b1)
            $display("FAIL midrst_rd: got %h empty=%b want 00 1", read_data, empty);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; write_data = 8'h00;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_boundary();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
